// File: rtl/worldselect_pkg.sv
// rtl/worldselect_pkg.sv - shared FSM encoding and map constants for world_request
// Purpose: state encoding, map index constants and one-hot map_en constants.
// Ports: none (package).
package worldselect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [1:0] MAP_IDX_0 = 2'd0;
    localparam logic [1:0] MAP_IDX_1 = 2'd1;
    localparam logic [1:0] MAP_IDX_2 = 2'd2;
    localparam logic [1:0] MAP_IDX_3 = 2'd3;

    localparam logic [3:0] MAP_EN_0 = 4'b0001;
    localparam logic [3:0] MAP_EN_1 = 4'b0010;
    localparam logic [3:0] MAP_EN_2 = 4'b0100;
    localparam logic [3:0] MAP_EN_3 = 4'b1000;

endpackage

// File: rtl/world_request_if.sv
// rtl/world_request_if.sv - request/acknowledge bus between world_request and the world selector
// Purpose: groups the map handshake and status signals.
// Signals: map_en (ack feedback, one-hot), map_change (request strobe),
//          map_select (requested index), busy, err.
// Modports: slave = world_request side, master = world selector / bench side.
interface world_request_if;
    logic [3:0] map_en;
    logic       map_change;
    logic [1:0] map_select;
    logic       busy;
    logic       err;

    modport slave (
        input  map_en,
        output map_change,
        output map_select,
        output busy,
        output err
    );

    modport master (
        output map_en,
        input  map_change,
        input  map_select,
        input  busy,
        input  err
    );
endinterface

// File: rtl/debounce.sv
// rtl/debounce.sv - 2-flop synchronizer plus debouncer for one raw input
// Purpose: synchronizes i_raw, then moves o_db to the synchronized value only
//          after it has differed for DEBOUNCE_CYCLES consecutive cycles.
//          o_low_settled reports that the synchronized input has been low for
//          DEBOUNCE_CYCLES consecutive cycles (a genuine, debounced release).
// Ports: i_clk, i_reset (async, active-high), i_raw (async input),
//        o_db (debounced level), o_low_settled (debounced release seen).
module debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_db,
    output logic o_low_settled
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CYCLES);

    logic          r_meta;
    logic          r_sync;
    logic          r_db;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_low_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_db      <= 1'b0;
            r_cnt     <= '0;
            r_low_cnt <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;

            // Any reversion to the current debounced level restarts the count.
            if (r_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_db  <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Saturating low-time counter. The synchronizer's reset zeros are
            // shorter than a debounce window, so a button held through reset
            // never looks like a release.
            if (r_sync) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt != CNT_FULL) begin
                r_low_cnt <= r_low_cnt + 1'b1;
            end
        end
    end

    assign o_db          = r_db;
    assign o_low_settled = (r_low_cnt == CNT_FULL);
endmodule

// File: rtl/world_request.sv
// rtl/world_request.sv - debounced "change world" request FSM with ack/timeout
// Purpose: on a debounced button press, latches the world-select switches,
//          strobes map_change for one cycle, waits for map_en to change (or a
//          timeout), then waits for the button to be released.
// Ports: i_clk, i_reset (async, active-high), i_btn_raw, i_sw_raw[1:0],
//        wr_bus (world_request_if.slave: map_en in; map_change, map_select,
//        busy, err out).
// Config: WORLDREQ_TIMEOUT_ERR_EN - when defined, a timeout sets sticky err,
//         cleared by the next acknowledge; otherwise err is tied to 0.
module world_request
    import worldselect_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACK_TIMEOUT     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_btn_raw,
    input  logic [1:0]            i_sw_raw,
    world_request_if.slave        wr_bus
);
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic            w_btn_db;
    logic            w_low_settled;
    logic            r_db_prev;
    logic            r_armed;
    logic [1:0]      r_sw_meta;
    logic [1:0]      r_sw_sync;
    logic [1:0]      r_map_select;
    logic [3:0]      r_snapshot;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_press;
    logic            w_ack;
    logic            w_to_last;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_raw         (i_btn_raw),
        .o_db          (w_btn_db),
        .o_low_settled (w_low_settled)
    );

    // A press is a debounced 0->1 edge that follows a debounced release;
    // this keeps a button held across reset from issuing a new request.
    assign w_press   = w_btn_db & ~r_db_prev & r_armed;
    assign w_ack     = (wr_bus.map_en != r_snapshot);
    assign w_to_last = (r_to_cnt == TO_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_press) w_next = ST_PULSE;
            ST_PULSE:    w_next = ST_WAIT_ACK;
            // Ack is tested first so an ack in the last timeout cycle wins.
            ST_WAIT_ACK: if (w_ack || w_to_last) w_next = ST_RELEASE;
            ST_RELEASE:  if (!w_btn_db) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_db_prev    <= 1'b0;
            r_armed      <= 1'b0;
            r_sw_meta    <= 2'b00;
            r_sw_sync    <= 2'b00;
            r_map_select <= MAP_IDX_0;
            r_snapshot   <= 4'b0000;
            r_to_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_db_prev <= w_btn_db;
            r_sw_meta <= i_sw_raw;
            r_sw_sync <= r_sw_meta;

            if (w_low_settled) begin
                r_armed <= 1'b1;
            end

            if (r_state == ST_IDLE && w_press) begin
                r_map_select <= r_sw_sync;
                r_snapshot   <= wr_bus.map_en;
                r_armed      <= 1'b0;
            end

            if (r_state == ST_PULSE) begin
                r_to_cnt <= '0;
            end else if (r_state == ST_WAIT_ACK && !w_ack && !w_to_last) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

`ifdef WORLDREQ_TIMEOUT_ERR_EN
    logic r_err;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else if (r_state == ST_WAIT_ACK) begin
            if (w_ack) begin
                r_err <= 1'b0;
            end else if (w_to_last) begin
                r_err <= 1'b1;
            end
        end
    end

    assign wr_bus.err = r_err;
`else
    assign wr_bus.err = 1'b0;
`endif

    assign wr_bus.map_change = (r_state == ST_PULSE);
    assign wr_bus.map_select = r_map_select;
    assign wr_bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_world_request.sv
// tb/tb_world_request.sv - directed self-checking bench for world_request
module tb_world_request;
    import worldselect_pkg::*;

`ifdef WORLDREQ_TIMEOUT_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_raw = 1'b0;
    logic [1:0] sw_raw = 2'b00;
    int         n_assert = 0;
    int         n_fail = 0;
    int         pulse_cnt = 0;
    int         pulse_mark;
    logic       busy_seen;

    world_request_if wr_bus ();

    world_request #(
        .DEBOUNCE_CYCLES(4),
        .ACK_TIMEOUT    (8)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_btn_raw (btn_raw),
        .i_sw_raw  (sw_raw),
        .wr_bus    (wr_bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_bus.map_change === 1'b1) pulse_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        while (wr_bus.map_change !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, 8'(wr_bus.map_change), 8'd1);
    endtask

    initial begin
        wr_bus.map_en = MAP_EN_0;
        tick(3);
        check("rst_change", 8'(wr_bus.map_change), 8'd0);
        check("rst_select", 8'(wr_bus.map_select), 8'(MAP_IDX_0));
        check("rst_busy",   8'(wr_bus.busy), 8'd0);
        check("rst_err",    8'(wr_bus.err), 8'd0);
        reset = 1'b0;
        tick(12);

        // Held press with ack two cycles after the strobe.
        sw_raw  = MAP_IDX_2;
        btn_raw = 1'b1;
        wait_strobe("p1_strobe");
        check("p1_select", 8'(wr_bus.map_select), 8'(MAP_IDX_2));
        check("p1_busy",   8'(wr_bus.busy), 8'd1);
        tick(2);
        wr_bus.map_en = MAP_EN_2;
        tick(12);
        check("p1_busy_held", 8'(wr_bus.busy), 8'd1);
        check("p1_pulses",    8'(pulse_cnt), 8'd1);
        check("p1_err",       8'(wr_bus.err), 8'd0);
        btn_raw = 1'b0;
        tick(10);
        check("p1_busy_rel",  8'(wr_bus.busy), 8'd0);

        // Bouncing button never settles.
        busy_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            btn_raw = ~btn_raw;
            tick();
            if (wr_bus.busy) busy_seen = 1'b1;
            tick();
            if (wr_bus.busy) busy_seen = 1'b1;
        end
        btn_raw = 1'b0;
        tick(10);
        check("bounce_busy",   8'(busy_seen), 8'd0);
        check("bounce_pulses", 8'(pulse_cnt), 8'd1);

        // No ack: timeout after 8 WAIT_ACK cycles.
        btn_raw = 1'b1;
        wait_strobe("to_strobe");
        tick(8);
        check("to_err_pre",  8'(wr_bus.err), 8'd0);
        tick();
        check("to_err_post", 8'(wr_bus.err), 8'(ERR_EXP));
        check("to_busy",     8'(wr_bus.busy), 8'd1);
        btn_raw = 1'b0;
        tick(10);
        check("to_idle",     8'(wr_bus.busy), 8'd0);
        check("to_err_hold", 8'(wr_bus.err), 8'(ERR_EXP));
        btn_raw = 1'b1;
        wait_strobe("to_ack_strobe");
        tick(2);
        wr_bus.map_en = MAP_EN_0;
        tick(3);
        check("to_err_clr",  8'(wr_bus.err), 8'd0);
        btn_raw = 1'b0;
        tick(10);
        check("to_pulses",   8'(pulse_cnt), 8'd3);

        // Switch change mid-request is ignored until the next press.
        sw_raw  = MAP_IDX_3;
        btn_raw = 1'b1;
        wait_strobe("sw_strobe1");
        check("sw_sel3", 8'(wr_bus.map_select), 8'(MAP_IDX_3));
        tick();
        sw_raw = MAP_IDX_1;
        tick(3);
        check("sw_sel3_wait", 8'(wr_bus.map_select), 8'(MAP_IDX_3));
        wr_bus.map_en = MAP_EN_2;
        tick(3);
        btn_raw = 1'b0;
        tick(10);
        check("sw_sel3_idle", 8'(wr_bus.map_select), 8'(MAP_IDX_3));
        btn_raw = 1'b1;
        wait_strobe("sw_strobe2");
        check("sw_sel1", 8'(wr_bus.map_select), 8'(MAP_IDX_1));
        tick(2);
        wr_bus.map_en = MAP_EN_0;
        tick(3);
        btn_raw = 1'b0;
        tick(10);
        check("sw_pulses", 8'(pulse_cnt), 8'd5);

        // Reset the cycle after the strobe with the button still held.
        sw_raw  = MAP_IDX_2;
        btn_raw = 1'b1;
        wait_strobe("rr_strobe");
        tick();
        reset = 1'b1;
        #1;
        check("rr_change", 8'(wr_bus.map_change), 8'd0);
        check("rr_select", 8'(wr_bus.map_select), 8'(MAP_IDX_0));
        check("rr_busy",   8'(wr_bus.busy), 8'd0);
        check("rr_err",    8'(wr_bus.err), 8'd0);
        tick();
        reset = 1'b0;
        pulse_mark = pulse_cnt;
        tick(30);
        check("rr_no_pulse", 8'(pulse_cnt - pulse_mark), 8'd0);
        check("rr_busy_held", 8'(wr_bus.busy), 8'd0);
        btn_raw = 1'b0;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/world_request.md
WORLD_REQUEST -- requirements
Module: world_request

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles needed before the debounced button changes.
REQ-002 Parameter ACK_TIMEOUT, default 32, maximum cycles spent waiting for the map_en acknowledge.
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_raw  input  1  raw "change world" pushbutton, asynchronous to clk.
REQ-006 sw_raw  input  2  raw world-select switches, asynchronous to clk.
REQ-007 map_en  input  4  one-hot map enable fed back from the world selector.
REQ-008 map_change  output  1  single-cycle request strobe to the world selector.
REQ-009 map_select  output  2  requested world index, stable while map_change is high.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 err  output  1  sticky acknowledge-timeout flag.

Function
REQ-012 btn_raw and sw_raw SHALL each pass through a 2-flop synchronizer before any other use.
REQ-013 Debounced button SHALL take the synchronized value only after it differs from the current debounced value for DEBOUNCE_CYCLES consecutive cycles; any reversion SHALL clear the stability counter.
REQ-014 FSM states SHALL be IDLE, PULSE, WAIT_ACK and RELEASE.
REQ-015 IDLE -> PULSE on the debounced button's 0->1 edge; in that same cycle, latch synchronized switches into map_select and snapshot map_en.
REQ-016 PULSE SHALL drive map_change high for exactly one cycle, then go to WAIT_ACK unconditionally.
REQ-017 WAIT_ACK SHALL exit to RELEASE when map_en differs from the snapshot (acknowledge) or after ACK_TIMEOUT cycles, whichever is first; an acknowledge in the final timeout cycle counts as acknowledge.
REQ-018 RELEASE SHALL return to IDLE on the first cycle the debounced button is 0; a held button SHALL never produce a second request.
REQ-019 map_select SHALL change only on the IDLE->PULSE transition and otherwise hold its last latched value.
REQ-020 Button edges arriving in PULSE, WAIT_ACK or RELEASE SHALL be ignored, not queued.
REQ-021 Switch changes outside the latch cycle SHALL have no effect on outputs.
REQ-022 Timeout counter width SHALL be ceil(log2(ACK_TIMEOUT+1)) bits and SHALL reload to 0 on entering WAIT_ACK.

Reset
REQ-023 Reset SHALL force IDLE, map_change=0, map_select=2'b00, busy=0, err=0, debounced button=0, and all counters, synchronizers and the snapshot to 0.
REQ-024 Reset asserted mid-request SHALL abort the request immediately, with no map_change pulse after deassertion unless a new debounced edge occurs.

Configuration
REQ-025 Macro WORLDREQ_TIMEOUT_ERR_EN: when defined, a timeout SHALL set err, and err SHALL clear on the next acknowledge or on reset.
REQ-026 When WORLDREQ_TIMEOUT_ERR_EN is undefined, err SHALL be tied to 0, and a timeout SHALL still silently move to RELEASE.

Structure
REQ-027 A shared package worldselect_pkg SHALL hold the FSM state encoding, the map index constants (0-3) and the one-hot map_en constants (0001/0010/0100/1000).
REQ-028 Synchronizer plus debouncer SHALL be one sub-module, debounce, parameterized by DEBOUNCE_CYCLES and instantiated once for the button.

Verification (DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8)
REQ-029 sw_raw=2'b10, btn_raw held high 20 cycles, map_en 0001 -> 0100 two cycles after the strobe -> exactly one map_change pulse with map_select=2, busy high until the button is released, err=0.
REQ-030 btn_raw toggling every 2 cycles for 30 cycles -> no map_change, busy stays 0.
REQ-031 Valid press, map_en held at 0001 -> after 8 WAIT_ACK cycles go to RELEASE with err=1; next press acknowledged -> err=0.
REQ-032 sw_raw changes 3->1 during WAIT_ACK -> map_select stays 3 until the next press, then becomes 1.
REQ-033 reset pulsed the cycle after map_change -> all outputs at reset values, no further pulse while the button remains held.
REQ-034 Build without WORLDREQ_TIMEOUT_ERR_EN, repeat REQ-031 -> err stays 0 and the FSM returns to IDLE on release.
